// File: rtl/instr_register_pkg.sv
// ---------------------------------------------------------------------------
// instr_register_pkg
// Shared types for the instruction register and its reader.
//   opcode_t      : 3-bit ALU opcode
//   operand_t     : signed 32-bit operand
//   address_t     : 5-bit register entry address
//   instruction_t : {opc, op_a, op_b}
//   result_t      : signed 64-bit ALU result
//   exec_state_t  : instr_exec_reader FSM state
// ---------------------------------------------------------------------------
package instr_register_pkg;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef logic [4:0] address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [63:0] result_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } exec_state_t;

    localparam int unsigned ADDR_W = $bits(address_t);

endpackage

// File: rtl/instr_alu.sv
// ---------------------------------------------------------------------------
// instr_alu
// Purely combinational ALU for one instruction_t.
//   instr   in  : opcode plus signed 32-bit operands a/b
//   result  out : signed 64-bit result
//   div_err out : DIV/MOD attempted with b == 0 (result forced to 0)
// ---------------------------------------------------------------------------
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output result_t      result,
    output logic         div_err
);

    // Everything is evaluated at 64 bits so MULT keeps its full product and
    // DIV of -2^31 by -1 yields +2^31 rather than wrapping.
    result_t a_ext;
    result_t b_ext;

    assign a_ext = result_t'(instr.op_a);
    assign b_ext = result_t'(instr.op_b);

    always_comb begin
        result  = '0;
        div_err = 1'b0;
        case (instr.opc)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            DIV: begin
                if (instr.op_b == '0) begin
                    div_err = 1'b1;
                end else begin
                    result = a_ext / b_ext;
                end
            end
            MOD: begin
                if (instr.op_b == '0) begin
                    div_err = 1'b1;
                end else begin
                    result = a_ext % b_ext;
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec_reader.sv
// ---------------------------------------------------------------------------
// instr_exec_reader
// Read-side consumer of the instruction register. On start it walks `count`
// entries from first_addr, executes each through instr_alu and offers the
// result on a valid/ready channel.
//   clk, reset_n       : clock, async active-low reset
//   start, first_addr,
//   count              : run request (start honoured only in IDLE)
//   read_pointer       : address to the instruction register
//   instruction_word   : combinational read data at read_pointer
//   res_valid/res_ready: result handshake
//   result, res_opcode,
//   res_addr, div_err  : result payload (div_err qualified by res_valid)
//   busy, done         : status; done is a one-cycle end-of-run pulse
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; read_pointer holds its last value
// FETCH | read_pointer = addr, capture instruction_word
// EXEC  | ALU evaluates captured word, result registered at the edge
// WAIT  | res_valid high, payload frozen until res_ready
// DONE  | done pulse for one cycle
// ---------------------------------------------------------------------------
module instr_exec_reader
    import instr_register_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 32,
    parameter int unsigned CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  address_t         first_addr,
    input  logic [CNT_W-1:0] count,
    output address_t         read_pointer,
    input  instruction_t     instruction_word,
    output logic             res_valid,
    input  logic             res_ready,
    output result_t          result,
    output opcode_t          res_opcode,
    output address_t         res_addr,
    output logic             div_err,
    output logic             busy,
    output logic             done
);

    exec_state_t      state;
    exec_state_t      state_next;

    address_t         addr_q;
    address_t         addr_next;
    logic [CNT_W-1:0] remaining_q;
    instruction_t     iw_q;

    result_t          result_q;
    opcode_t          opcode_q;
    address_t         res_addr_q;
    logic             div_err_q;

    result_t          alu_result;
    logic             alu_div_err;

    logic             accept;
    logic             last_entry;

    instr_alu u_alu (
        .instr   (iw_q),
        .result  (alu_result),
        .div_err (alu_div_err)
    );

    assign accept     = (state == WAIT) && res_ready;
    assign last_entry = (remaining_q == CNT_W'(1));

    // Explicit wrap keeps the behaviour defined even if the address type is
    // ever widened beyond the register depth.
    assign addr_next = (addr_q == address_t'(NUM_ENTRIES - 1)) ? '0 : addr_q + address_t'(1);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count != '0) ? FETCH : DONE;
                end
            end
            FETCH: state_next = EXEC;
            EXEC:  state_next = WAIT;
            WAIT: begin
                if (accept) begin
                    state_next = last_entry ? DONE : FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE:  busy = 1'b0;
            FETCH: busy = 1'b1;
            EXEC:  busy = 1'b1;
            WAIT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Datapath. The instruction word is only sampled in FETCH, so an unused
    // or undriven register entry never reaches iw_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= '0;
            remaining_q <= '0;
            iw_q        <= '0;
            result_q    <= '0;
            opcode_q    <= ZERO;
            res_addr_q  <= '0;
            div_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (count != '0)) begin
                        addr_q      <= first_addr;
                        remaining_q <= count;
                    end
                end
                FETCH: begin
                    iw_q <= instruction_word;
                end
                EXEC: begin
                    result_q   <= alu_result;
                    opcode_q   <= iw_q.opc;
                    res_addr_q <= addr_q;
                    div_err_q  <= alu_div_err;
                end
                WAIT: begin
                    if (accept && !last_entry) begin
                        addr_q      <= addr_next;
                        remaining_q <= remaining_q - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign read_pointer = addr_q;
    assign result       = result_q;
    assign res_opcode   = opcode_q;
    assign res_addr     = res_addr_q;
    assign div_err      = div_err_q;

endmodule

// File: tb/tb_instr_exec_reader.sv
module tb_instr_exec_reader;
    import instr_register_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         start;
    address_t     first_addr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         res_valid;
    logic         res_ready;
    result_t      result;
    opcode_t      res_opcode;
    address_t     res_addr;
    logic         div_err;
    logic         busy;
    logic         done;

    instruction_t mem [32];
    int           tests;
    int           fails;
    int           hs_cnt;
    int           done_cnt;
    int           snap;

    instr_exec_reader #(.NUM_ENTRIES(32), .CNT_W(6)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .result           (result),
        .res_opcode       (res_opcode),
        .res_addr         (res_addr),
        .div_err          (div_err),
        .busy             (busy),
        .done             (done)
    );

    assign instruction_word = mem[read_pointer];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset_n && res_valid && res_ready) hs_cnt <= hs_cnt + 1;
        if (reset_n && done) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single-entry run with res_ready held high: FETCH, EXEC, WAIT, DONE.
    task automatic run_one(input string tag, input address_t ad, input opcode_t op,
                           input operand_t a, input operand_t b,
                           input logic [63:0] exp_res, input logic exp_err);
        mem[ad]    = '{opc: op, op_a: a, op_b: b};
        first_addr = ad;
        count      = 6'd1;
        res_ready  = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_rp"}, 64'(read_pointer), 64'(ad));
        tick();
        tick();
        chk({tag, "_valid"}, 64'(res_valid), 64'd1);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_div_err"}, 64'(div_err), 64'(exp_err));
        tick();
        chk({tag, "_done"}, 64'(done), 64'd1);
        tick();
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        hs_cnt     = 0;
        done_cnt   = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        reset_n    = 1'b0;
        start      = 1'b0;
        first_addr = '0;
        count      = '0;
        res_ready  = 1'b0;

        #12;
        chk("rst_rp", 64'(read_pointer), 64'd0);
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", result, 64'd0);
        #1 reset_n = 1'b1;
        tick();

        // Basic ADD with cycle-by-cycle timing
        mem[0]     = '{opc: ADD, op_a: 32'sd5, op_b: 32'sd7};
        first_addr = 5'd0;
        count      = 6'd1;
        res_ready  = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("add_c1_rp", 64'(read_pointer), 64'd0);
        chk("add_c1_busy", 64'(busy), 64'd1);
        chk("add_c1_valid", 64'(res_valid), 64'd0);
        tick();
        chk("add_c2_valid", 64'(res_valid), 64'd0);
        tick();
        chk("add_c3_valid", 64'(res_valid), 64'd1);
        chk("add_result", result, 64'd12);
        chk("add_addr", 64'(res_addr), 64'd0);
        chk("add_opc", 64'(res_opcode), 64'(ADD));
        chk("add_div_err", 64'(div_err), 64'd0);
        tick();
        chk("add_c4_done", 64'(done), 64'd1);
        chk("add_c4_valid", 64'(res_valid), 64'd0);
        tick();
        chk("add_c5_done", 64'(done), 64'd0);
        chk("add_c5_busy", 64'(busy), 64'd0);
        chk("add_idle_rp_hold", 64'(read_pointer), 64'd0);

        // ALU vectors
        run_one("mult_neg", 5'd3, MULT, -32'sd3, 32'sd100000, 64'hFFFF_FFFF_FFFB_6C20, 1'b0);
        run_one("mult_max", 5'd4, MULT, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0);
        run_one("div_neg", 5'd7, DIV, -32'sd7, 32'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
        run_one("mod_neg", 5'd8, MOD, -32'sd7, 32'sd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_one("div_zero", 5'd9, DIV, 32'sd7, 32'sd0, 64'd0, 1'b1);
        run_one("mod_zero", 5'd10, MOD, 32'sd7, 32'sd0, 64'd0, 1'b1);
        run_one("sub", 5'd11, SUB, 32'sd3, 32'sd10, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);

        // Address wrap 30,31,0,1
        mem[30] = '{opc: PASSA, op_a: 32'sd100, op_b: 32'sd0};
        mem[31] = '{opc: PASSA, op_a: 32'sd101, op_b: 32'sd0};
        mem[0]  = '{opc: PASSA, op_a: 32'sd102, op_b: 32'sd0};
        mem[1]  = '{opc: PASSA, op_a: 32'sd103, op_b: 32'sd0};
        snap       = hs_cnt;
        first_addr = 5'd30;
        count      = 6'd4;
        res_ready  = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_rp%0d", i), 64'(read_pointer), 64'((30 + i) % 32));
            tick();
            tick();
            chk($sformatf("wrap_valid%0d", i), 64'(res_valid), 64'd1);
            chk($sformatf("wrap_addr%0d", i), 64'(res_addr), 64'((30 + i) % 32));
            chk($sformatf("wrap_result%0d", i), result, 64'(100 + i));
            tick();
        end
        chk("wrap_done", 64'(done), 64'd1);
        chk("wrap_handshakes", 64'(hs_cnt - snap), 64'd4);
        tick();

        // Backpressure, with an ignored start while busy
        mem[5]     = '{opc: SUB, op_a: 32'sd10, op_b: 32'sd3};
        mem[6]     = '{opc: PASSB, op_a: 32'sd1, op_b: -32'sd9};
        first_addr = 5'd5;
        count      = 6'd2;
        res_ready  = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                start      = 1'b1;
                first_addr = 5'd20;
                count      = 6'd3;
            end else begin
                start = 1'b0;
            end
            chk($sformatf("hold_valid%0d", i), 64'(res_valid), 64'd1);
            chk($sformatf("hold_result%0d", i), result, 64'd7);
            chk($sformatf("hold_addr%0d", i), 64'(res_addr), 64'd5);
            chk($sformatf("hold_rp%0d", i), 64'(read_pointer), 64'd5);
            tick();
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("hold_next_rp", 64'(read_pointer), 64'd6);
        chk("hold_next_valid", 64'(res_valid), 64'd0);
        tick();
        tick();
        chk("hold2_valid", 64'(res_valid), 64'd1);
        chk("hold2_result", result, 64'hFFFF_FFFF_FFFF_FFF7);
        chk("hold2_addr", 64'(res_addr), 64'd6);
        res_ready = 1'b1;
        tick();
        chk("hold_done", 64'(done), 64'd1);
        tick();
        chk("hold_idle", 64'(busy), 64'd0);

        // Reset mid-WAIT
        mem[2]     = '{opc: ADD, op_a: 32'sd1, op_b: 32'sd1};
        first_addr = 5'd2;
        count      = 6'd3;
        res_ready  = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_pre_valid", 64'(res_valid), 64'd1);
        snap = done_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_result", result, 64'd0);
        chk("mid_rst_rp", 64'(read_pointer), 64'd0);
        chk("mid_rst_addr", 64'(res_addr), 64'd0);
        chk("mid_rst_opc", 64'(res_opcode), 64'd0);
        #2 reset_n = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_no_done", 64'(done_cnt - snap), 64'd0);
        chk("mid_idle", 64'(busy), 64'd0);

        // count == 0
        snap       = hs_cnt;
        first_addr = 5'd9;
        count      = 6'd0;
        res_ready  = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("cnt0_done", 64'(done), 64'd1);
        chk("cnt0_valid", 64'(res_valid), 64'd0);
        chk("cnt0_rp_hold", 64'(read_pointer), 64'd0);
        tick();
        chk("cnt0_done_end", 64'(done), 64'd0);
        chk("cnt0_no_hs", 64'(hs_cnt - snap), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
